// File: rtl/cut_response_misr.sv
// cut_response_misr
// Multiple-input signature register that compacts the primary-output vectors
// of a circuit-under-test. A run starts on an accepted start pulse. Each
// accepted beat is folded into the signature. Once the programmed number of
// patterns has been seen, the final signature is compared with the golden
// value latched at start, and pass/fail is reported.
//
// Ports
//   clk, rst      : clock; asynchronous active-high reset
//   start         : begin a run (honoured in IDLE or DONE only)
//   num_patterns  : beats per run, sampled on an accepted start
//   golden_sig    : expected final signature, sampled on an accepted start
//   resp_valid    : resp_data carries a CUT output vector
//   resp_data     : CUT output vector
//   resp_ready    : high in RUN
//   busy          : high in RUN
//   done          : high in DONE
//   pass          : in DONE, signature matched golden; 0 elsewhere
//   signature     : current MISR value
//   pat_count     : beats accepted in the current run
//   dbg_state     : FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a beat transfers on a rising edge where resp_valid && resp_ready.
// resp_ready does not depend on resp_valid. The source may hold or drop
// resp_valid freely, and a cycle with resp_valid low changes nothing.
module cut_response_misr #(
  parameter int               WIDTH = 108,
  parameter logic [WIDTH-1:0] POLY  = {{(WIDTH-7){1'b0}}, 7'h41},
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [WIDTH-1:0] golden_sig,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] pat_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sig;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_num;
  logic [WIDTH-1:0] r_golden;
  logic             r_pass;

  logic             w_start_ok;
  logic             w_accept;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_sig_next;

  assign w_start_ok = start && (r_state != S_RUN);
  assign w_accept   = resp_valid && (r_state == S_RUN);
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_last     = w_accept && (w_cnt_inc == r_num);

  // Shift left, fold the tap mask back in when the bit shifted out was 1,
  // then XOR in the new response vector.
  assign w_sig_next = {r_sig[WIDTH-2:0], 1'b0}
                    ^ (r_sig[WIDTH-1] ? POLY : '0)
                    ^ resp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_next = (num_patterns == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig    <= SEED;
      r_cnt    <= '0;
      r_num    <= '0;
      r_golden <= '0;
      r_pass   <= 1'b0;
    end else if (w_start_ok) begin
      r_num    <= num_patterns;
      r_golden <= golden_sig;
      r_sig    <= SEED;
      r_cnt    <= '0;
      // A zero-length run goes straight to DONE, so its verdict is the seed
      // compared against the golden value being latched now.
      r_pass   <= (num_patterns == '0) && (SEED == golden_sig);
    end else if (w_accept) begin
      r_sig <= w_sig_next;
      r_cnt <= w_cnt_inc;
      if (w_last) r_pass <= (w_sig_next == r_golden);
    end
  end

  assign resp_ready = (r_state == S_RUN);
  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign pass       = r_pass && (r_state == S_DONE);
  assign signature  = r_sig;
  assign pat_count  = r_cnt;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_cut_response_misr.sv
module tb_cut_response_misr;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int WW = 108;
  localparam int WC = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- narrow DUT ----------------
  logic          start = 0;
  logic [CW-1:0] num_patterns = '0;
  logic [W-1:0]  golden_sig = '0;
  logic          resp_valid = 0;
  logic [W-1:0]  resp_data = '0;
  logic          resp_ready, busy, done, pass;
  logic [W-1:0]  signature;
  logic [CW-1:0] pat_count;
  logic [1:0]    dbg_state;

  cut_response_misr #(.WIDTH(W), .POLY(8'h1D), .SEED(8'h00), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_patterns(num_patterns),
    .golden_sig(golden_sig), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(resp_ready), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .pat_count(pat_count), .dbg_state(dbg_state)
  );

  // ---------------- wide DUT (default parameters) ----------------
  logic          w_start = 0;
  logic [WC-1:0] w_num = '0;
  logic [WW-1:0] w_golden = '0;
  logic          w_valid = 0;
  logic [WW-1:0] w_data = '0;
  logic          w_ready, w_busy, w_done, w_pass;
  logic [WW-1:0] w_sig;
  logic [WC-1:0] w_cnt;
  logic [1:0]    w_dbg;

  cut_response_misr dut_w (
    .clk(clk), .rst(rst), .start(w_start), .num_patterns(w_num),
    .golden_sig(w_golden), .resp_valid(w_valid), .resp_data(w_data),
    .resp_ready(w_ready), .busy(w_busy), .done(w_done), .pass(w_pass),
    .signature(w_sig), .pat_count(w_cnt), .dbg_state(w_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_sig;
  logic [CW-1:0] m_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref8(input logic [W-1:0] s, input logic [W-1:0] d);
    logic [W-1:0] t;
    t = s << 1;
    if (s[W-1]) t = t ^ 8'h1D;
    return t ^ d;
  endfunction

  function automatic logic [WW-1:0] ref108(input logic [WW-1:0] s, input logic [WW-1:0] d);
    logic [WW-1:0] t;
    t = s << 1;
    if (s[WW-1]) t = t ^ 108'h41;
    return t ^ d;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CW-1:0] n, input logic [W-1:0] g);
    start = 1; num_patterns = n; golden_sig = g;
    tick();
    start = 0;
    m_sig = 8'h00;
    m_cnt = '0;
  endtask

  task automatic beat(input logic [W-1:0] d, input string tag);
    resp_valid = 1; resp_data = d;
    m_sig = ref8(m_sig, d);
    m_cnt = m_cnt + 1'b1;
    exp_q.push_back(m_sig);
    tick();
    resp_valid = 0; resp_data = '0;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard underflow", tag);
    end else begin
      chk({tag, "_sig"}, signature, exp_q.pop_front());
      chk({tag, "_cnt"}, pat_count, m_cnt);
    end
  endtask

  logic [WW-1:0] vecs[10];
  logic [127:0]  tmp;
  logic [WW-1:0] wm;
  int            fv, fb;

  initial begin
    // reset state
    #12;
    chk("rst_sig", signature, 8'h00);
    chk("rst_cnt", pat_count, 4'd0);
    chk("rst_flags", {busy, done, pass, resp_ready}, 4'b0000);
    @(negedge clk); rst = 0;
    tick();
    chk("idle_state", {busy, done, resp_ready}, 3'b000);

    // basic signature
    do_start(4'd3, 8'h19);
    chk("start_busy", {busy, resp_ready, done}, 3'b110);
    beat(8'h01, "b1");
    chk("b1_const", signature, 8'h01);
    beat(8'h80, "b2");
    chk("b2_const", signature, 8'h82);
    beat(8'h00, "b3");
    chk("b3_const", signature, 8'h19);
    chk("basic_done", {done, pass, busy, resp_ready}, 4'b1100);

    // beats presented in DONE are ignored
    resp_valid = 1; resp_data = 8'hFF;
    tick(); tick();
    resp_valid = 0;
    chk("done_ign_sig", signature, 8'h19);
    chk("done_ign_cnt", pat_count, 4'd3);
    chk("done_hold", {done, pass}, 2'b11);

    // mismatch; restart directly from DONE
    do_start(4'd3, 8'h18);
    chk("restart_flags", {done, pass, busy}, 3'b001);
    chk("restart_sig", signature, 8'h00);
    beat(8'h01, "m1"); beat(8'h80, "m2"); beat(8'h00, "m3");
    chk("mis_done", {done, pass}, 2'b10);
    chk("mis_sig", signature, 8'h19);

    // gaps plus start asserted mid-run
    do_start(4'd3, 8'h19);
    beat(8'h01, "g1");
    tick(); tick();
    chk("gap_hold_sig", signature, 8'h01);
    chk("gap_hold_cnt", pat_count, 4'd1);
    start = 1; num_patterns = 4'd1; golden_sig = 8'h00;
    tick();
    start = 0;
    chk("midrun_start_ign", {busy, done, pat_count, signature}, {2'b10, 4'd1, 8'h01});
    beat(8'h80, "g2");
    tick();
    beat(8'h00, "g3");
    chk("gap_done", {done, pass, pat_count, signature}, {2'b11, 4'd3, 8'h19});

    // zero patterns
    do_start(4'd0, 8'h00);
    chk("zero_done", {done, pass, busy, resp_ready}, 4'b1100);
    chk("zero_sig", signature, 8'h00);
    chk("zero_cnt", pat_count, 4'd0);

    // reset mid-run, asserted between edges
    do_start(4'd3, 8'h19);
    beat(8'h01, "r1");
    #2 rst = 1;
    #1;
    chk("async_rst_sig", signature, 8'h00);
    chk("async_rst_cnt", pat_count, 4'd0);
    chk("async_rst_flags", {busy, done, pass, resp_ready}, 4'b0000);
    @(negedge clk); rst = 0;
    resp_valid = 1; resp_data = 8'h55;
    tick();
    resp_valid = 0;
    chk("idle_ign", {busy, pat_count, signature}, {1'b0, 4'd0, 8'h00});
    do_start(4'd3, 8'h19);
    beat(8'h01, "p1"); beat(8'h80, "p2"); beat(8'h00, "p3");
    chk("post_rst_run", {done, pass, signature}, {2'b11, 8'h19});

    // wide instance: 10 random response vectors, golden from reference model
    wm = '0;
    for (int i = 0; i < 10; i++) begin
      tmp = {$urandom, $urandom, $urandom, $urandom};
      vecs[i] = tmp[WW-1:0];
      wm = ref108(wm, vecs[i]);
    end
    for (int pass_no = 0; pass_no < 2; pass_no++) begin
      if (pass_no == 1) begin
        fv = $urandom_range(0, 9);
        fb = $urandom_range(0, WW-1);
        vecs[fv][fb] = ~vecs[fv][fb];
      end
      w_start = 1; w_num = 16'd10; w_golden = wm;
      tick();
      w_start = 0;
      for (int i = 0; i < 10; i++) begin
        w_valid = 1; w_data = vecs[i];
        tick();
      end
      w_valid = 0;
      chk("wide_cnt", w_cnt, 16'd10);
      chk("wide_done", w_done, 1'b1);
      chk(pass_no == 0 ? "wide_pass" : "wide_flip_fail", w_pass, pass_no == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cut_response_misr.md
# cut_response_misr

Response compactor that sits directly downstream of the ISCAS-85 circuit-under-test (default width matches the c7552 108-bit primary-output vector) in the ATPG flow. It accepts one output vector per valid beat and folds it into a multiple-input signature register (MISR). After a programmed number of patterns it compares the signature against a golden value and reports pass/fail. This lets a vector run be checked in hardware without dumping every response.

## Interface
- WIDTH, 108: response vector width; also the MISR width.
- POLY, 108'h...0000_0000_0000_0000_0000_0041: feedback tap mask, applied when the MISR MSB is 1.
- SEED, all zeros: MISR value loaded at start.
- CNT_W, 16: width of the pattern counter and `num_patterns`.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- num_patterns  in  CNT_W  patterns per run; sampled on an accepted start.
- golden_sig  in  WIDTH  expected final signature; sampled on an accepted start.
- resp_valid  in  1  resp_data holds a CUT output vector this cycle.
- resp_data  in  WIDTH  CUT output vector.
- resp_ready  out  1  high in RUN only; a beat is accepted when resp_valid && resp_ready.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; held until the next accepted start or reset.
- pass  out  1  in DONE, signature == latched golden; 0 in every other state.
- signature  out  WIDTH  current MISR value.
- pat_count  out  CNT_W  number of beats accepted in the current run.

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, any state) puts the block in IDLE:
  - signature = SEED; pat_count = 0.
  - busy, done, pass, resp_ready = 0.
  - Latched num_patterns and golden_sig = 0.
- IDLE or DONE with start=1:
  - Latch num_patterns and golden_sig.
  - Load signature = SEED and pat_count = 0.
  - Next state is RUN. If the latched num_patterns == 0, next state is DONE directly.
- RUN, accepted beat:
  - signature ← {signature[WIDTH-2:0],1'b0} ^ (signature[WIDTH-1] ? POLY : 0) ^ resp_data.
  - pat_count ← pat_count + 1.
  - If pat_count+1 == latched num_patterns, next state is DONE.
- RUN, resp_valid=0: hold everything. There is no timeout.
- start in RUN is ignored. A run cannot be aborted except by reset.
- resp_valid in IDLE/DONE is ignored: resp_ready=0, and signature and count are unchanged.
- DONE:
  - signature and pat_count hold.
  - pass = (signature == golden latched), registered on entry to DONE.
  - pass stays stable through DONE.
- pat_count never wraps within a run, because the run ends at num_patterns ≤ 2^CNT_W−1.

## Timing
- Beat accepted at edge N → signature/pat_count updated visible after edge N.
- Last beat at edge N → state = DONE, done=1, pass valid after the same edge N. Latency is 0 extra cycles.
- start at edge N → busy=1 and resp_ready=1 after edge N. The first beat can be accepted at edge N+1.
- Back-to-back beats are accepted every cycle: full throughput, with no bubbles.
- start at the same edge that done is high restarts cleanly: done=0, pass=0, signature=SEED after that edge.
- rst asserted mid-RUN: outputs take their reset values immediately, without waiting for a clock edge. After rst deasserts, the block waits in IDLE for start.

## Test plan
For compact vectors, the bench uses WIDTH=8, POLY=8'h1D, SEED=8'h00, CNT_W=4 unless noted.
- Basic signature: start, num_patterns=3, golden=8'h19; beats 8'h01, 8'h80, 8'h00 on consecutive cycles.
  - Signature after each beat is 01, 82, 19.
  - done=1 and pass=1 after the 3rd edge; pat_count=3.
- Mismatch: same stimulus with golden=8'h18 → done=1, pass=0, signature=8'h19.
- Gaps and ignored traffic:
  - resp_valid toggled with idle cycles between the three beats → same final 8'h19.
  - Beats presented in IDLE/DONE → no change to signature or count.
  - start asserted mid-RUN → ignored.
- Zero patterns: start with num_patterns=0, golden=8'h00 → DONE the cycle after start, pass=1, signature=8'h00, resp_ready never high.
- Reset mid-run: assert rst asynchronously between clock edges after 1 beat.
  - Immediately: signature=00, pat_count=0, busy=done=pass=0.
  - After release, a new 3-beat run yields 8'h19 with pass=1.
- Default WIDTH=108 with c7552 responses: apply 10 vectors with golden equal to the reference-model signature → pass=1. Flipping one bit in any response → pass=0.
